// File: rtl/wb_regfile_sb_pkg.sv
// wb_regfile_sb_pkg
// Shared widths, types and constants for the writeback-side register file
// and its pending-write scoreboard. Holds what a shared defines header would
// otherwise provide (register word width, register address width, register
// count and the all-zero word).
package wb_regfile_sb_pkg;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 2;

    typedef logic [XLEN-1:0]  reg_word_t;
    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [CNT_W-1:0] sb_cnt_t;

    localparam reg_word_t ZERO_WORD = '0;
    localparam sb_cnt_t   CNT_MAX   = '1;

    // True when the writeback port is delivering a value for register addr
    // in the current cycle.
    function automatic logic wb_hits(input logic      wb_ena,
                                     input reg_addr_t wb_addr,
                                     input reg_addr_t addr);
        return wb_ena && (wb_addr == addr);
    endfunction

endpackage

// File: rtl/wb_regfile_sb_counter_bank.sv
// wb_regfile_sb_counter_bank
// Per-register pending-write counters (the scoreboard's sb_counter_bank).
// Each counter tracks instructions that were issued with that register as
// destination but have not yet written back.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset, clears all counters
//   flush      clears all counters, dominating inc/dec
//   inc        an issuing instruction claims inc_addr
//   inc_addr   destination of the issuing instruction
//   dec_ena    writeback valid
//   dec_addr   writeback destination
//   look_addr  three lookup addresses (rs1, rs2, issue rd)
//   look_cnt   current counter values for the lookup addresses
module wb_regfile_sb_counter_bank
    import wb_regfile_sb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                inc,
    input  reg_addr_t           inc_addr,
    input  logic                dec_ena,
    input  reg_addr_t           dec_addr,
    input  reg_addr_t [2:0]     look_addr,
    output sb_cnt_t   [2:0]     look_cnt
);

    sb_cnt_t cnt_q [NREG];
    sb_cnt_t cnt_d [NREG];

    // Next-count computation. A writeback against an already-zero counter is
    // a stale writeback left over from a flush and must not wrap the count.
    // An inc and a dec on the same register cancel out.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush || r == 0) begin
                cnt_d[r] = '0;
            end else begin
                if ((inc && inc_addr == reg_addr_t'(r)) &&
                    !(dec_ena && dec_addr == reg_addr_t'(r) && cnt_q[r] != '0)) begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end else if (!(inc && inc_addr == reg_addr_t'(r)) &&
                             (dec_ena && dec_addr == reg_addr_t'(r) && cnt_q[r] != '0)) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lookups reflect the registered counts only, so they never depend on
    // this cycle's issue decision.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            look_cnt[i] = cnt_q[look_addr[i]];
        end
    end

endmodule

// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb
// Integer register file on the receiving end of the writeback interface,
// with two combinational decode read ports (write-through bypass from the
// writeback port) and a pending-write scoreboard that stalls decode on RAW
// hazards and on pending-counter overflow.
//
// Ports:
//   clk, rst                   clock; synchronous active-low reset
//   wb_ena/wb_addr/wb_data     writeback valid, destination, value
//   rs1_ren/rs1_addr           decode source 1 read
//   rs2_ren/rs2_addr           decode source 2 read
//   issue_valid                decode presents an instruction this cycle
//   issue_rd_wen/issue_rd_addr that instruction's destination
//   flush                      clears the scoreboard
//   rs1_data/rs2_data          operands
//   stall                      instruction is held this cycle
module wb_regfile_sb
    import wb_regfile_sb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wb_ena,
    input  reg_addr_t wb_addr,
    input  reg_word_t wb_data,
    input  logic      rs1_ren,
    input  reg_addr_t rs1_addr,
    input  logic      rs2_ren,
    input  reg_addr_t rs2_addr,
    input  logic      issue_valid,
    input  logic      issue_rd_wen,
    input  reg_addr_t issue_rd_addr,
    input  logic      flush,
    output reg_word_t rs1_data,
    output reg_word_t rs2_data,
    output logic      stall
);

    reg_word_t regs_q [NREG];
    reg_word_t regs_d [NREG];

    sb_cnt_t [2:0] look_cnt;
    logic          haz1;
    logic          haz2;
    logic          ovf;
    logic          inc;

    // Register array next state; x0 is forced to zero so writes to it vanish.
    always_comb begin
        regs_d = regs_q;
        if (wb_ena && wb_addr != '0) begin
            regs_d[wb_addr] = wb_data;
        end
        regs_d[0] = ZERO_WORD;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '{default: ZERO_WORD};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: zero for unused/x0 reads, then bypass, then the array.
    always_comb begin
        rs1_data = ZERO_WORD;
        rs2_data = ZERO_WORD;
        if (rst) begin
            if (rs1_ren && rs1_addr != '0) begin
                rs1_data = wb_hits(wb_ena, wb_addr, rs1_addr) ? wb_data : regs_q[rs1_addr];
            end
            if (rs2_ren && rs2_addr != '0) begin
                rs2_data = wb_hits(wb_ena, wb_addr, rs2_addr) ? wb_data : regs_q[rs2_addr];
            end
        end
    end

    // Hazard detection. A single outstanding writer retiring this cycle is
    // covered by the bypass, so it does not hold decode. Overflow protects
    // the counter from wrapping unless a writeback frees a slot right now.
    always_comb begin
        haz1 = rs1_ren && rs1_addr != '0 && look_cnt[0] != '0 &&
               !(look_cnt[0] == sb_cnt_t'(1) && wb_hits(wb_ena, wb_addr, rs1_addr));
        haz2 = rs2_ren && rs2_addr != '0 && look_cnt[1] != '0 &&
               !(look_cnt[1] == sb_cnt_t'(1) && wb_hits(wb_ena, wb_addr, rs2_addr));
        ovf  = issue_rd_wen && issue_rd_addr != '0 && look_cnt[2] == CNT_MAX &&
               !wb_hits(wb_ena, wb_addr, issue_rd_addr);
        stall = rst && issue_valid && (haz1 || haz2 || ovf);
        inc   = issue_valid && !stall && issue_rd_wen && issue_rd_addr != '0;
    end

    wb_regfile_sb_counter_bank u_counter_bank (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .inc       (inc),
        .inc_addr  (issue_rd_addr),
        .dec_ena   (wb_ena),
        .dec_addr  (wb_addr),
        .look_addr ({issue_rd_addr, rs2_addr, rs1_addr}),
        .look_cnt  (look_cnt)
    );

endmodule
